// File: rtl/du_pkg.sv
// Debug-unit shared definitions: loader FSM state encoding and the UART handshake
// codes that the loader sends and du_master recognises.
package du_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_RESP   = 3'd5,
    ST_DONE   = 3'd6
  } du_state_e;

  localparam logic [7:0] DU_ACK = 8'h05;
  localparam logic [7:0] DU_NAK = 8'h15;

endpackage

// File: rtl/du_loader.sv
// UART program loader: receives a length-prefixed, checksummed frame of
// little-endian instruction words, writes them to IMEM and answers ACK/NAK.
module du_loader
  import du_pkg::*;
#(
  parameter int          NB_INSTRUCTION = 32,
  parameter int          NB_UART_DATA   = 8,
  parameter int          NB_IMEM_ADDR   = 10,
  parameter logic [31:0] TIMEOUT_TICKS  = 32'd99_999_999
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_rx_done,
  input  logic [NB_UART_DATA-1:0]   i_rx_data,
  output logic                      o_rd,
  output logic                      o_wr,
  output logic                      o_tx_start,
  output logic [NB_UART_DATA-1:0]   o_wdata,
  output logic                      o_imem_we,
  output logic [NB_IMEM_ADDR-1:0]   o_imem_addr,
  output logic [NB_INSTRUCTION-1:0] o_imem_wdata,
  output logic                      o_done,
  output logic                      o_error
);

  localparam int                NB_WIDX   = NB_IMEM_ADDR + 1;
  localparam logic [16:0]       MAX_WORDS = 17'd1 << NB_IMEM_ADDR;
  localparam logic [NB_WIDX-1:0] WIDX_ONE = 1;

  du_state_e                        state, state_n;
  logic [NB_UART_DATA-1:0]          len_lo, sum;
  logic [15:0]                      len, len_rx;
  logic [NB_WIDX-1:0]               word_idx;
  logic [1:0]                       byte_idx;
  logic [2:0][NB_UART_DATA-1:0]     asm_q;
  logic [31:0]                      tmr;
  logic                             nak, nak_n;
  logic                             rd, wr, adv, timeout, last_word, len_bad;

  assign len_rx    = 16'({i_rx_data, len_lo});
  assign len_bad   = (len_rx == 16'd0) || (17'(len_rx) > MAX_WORDS);
  assign last_word = (17'(word_idx) + 17'd1) == 17'(len);
  assign timeout   = tmr >= TIMEOUT_TICKS;
  // a byte popped while i_start is low is discarded: the FSM is leaving anyway
  assign adv       = rd & i_start;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      nak   <= 1'b0;
    end else begin
      state <= state_n;
      nak   <= nak_n;
    end
  end

  always_comb begin
    state_n = state;
    nak_n   = nak;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state)
      ST_IDLE:   if (i_start) state_n = ST_LEN_LO;
      ST_LEN_LO: begin
        rd = i_rx_done;
        if (rd) state_n = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        rd = i_rx_done;
        if (rd) begin
          state_n = len_bad ? ST_RESP : ST_DATA;
          nak_n   = len_bad;
        end else if (timeout) begin
          state_n = ST_RESP;
          nak_n   = 1'b1;
        end
      end
      ST_DATA: begin
        rd = i_rx_done;
        if (rd) begin
          if (byte_idx == 2'd3 && last_word) state_n = ST_CHECK;
        end else if (timeout) begin
          state_n = ST_RESP;
          nak_n   = 1'b1;
        end
      end
      ST_CHECK: begin
        rd = i_rx_done;
        if (rd) begin
          state_n = ST_RESP;
          nak_n   = (i_rx_data != sum);
        end else if (timeout) begin
          state_n = ST_RESP;
          nak_n   = 1'b1;
        end
      end
      ST_RESP: begin
        wr      = 1'b1;
        state_n = nak ? ST_LEN_LO : ST_DONE;
      end
      ST_DONE:   state_n = ST_DONE;
      default:   state_n = ST_IDLE;
    endcase
    if (!i_start) begin
      state_n = ST_IDLE;
      wr      = 1'b0;
    end
  end

  assign o_rd       = rd;
  assign o_wr       = wr;
  assign o_tx_start = wr;
  assign o_wdata    = wr ? NB_UART_DATA'(nak ? DU_NAK : DU_ACK) : '0;
  assign o_error    = wr & nak;
  assign o_done     = (state == ST_DONE);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr          <= '0;
      len_lo       <= '0;
      len          <= '0;
      sum          <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      asm_q        <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
    end else begin
      o_imem_we <= 1'b0;
      // idle states keep the counter at zero so LEN_LO is always entered fresh
      if (rd || state == ST_IDLE || state == ST_RESP || state == ST_DONE) tmr <= '0;
      else if (!timeout)                                                  tmr <= tmr + 32'd1;

      if (state == ST_IDLE || (state == ST_RESP && nak)) begin
        sum      <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        asm_q    <= '0;
      end else if (adv) begin
        case (state)
          ST_LEN_LO: len_lo <= i_rx_data;
          ST_LEN_HI: begin
            len      <= len_rx;
            sum      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
          end
          ST_DATA: begin
            sum      <= sum + i_rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              o_imem_we    <= 1'b1;
              o_imem_addr  <= word_idx[NB_IMEM_ADDR-1:0];
              o_imem_wdata <= NB_INSTRUCTION'({i_rx_data, asm_q});
              word_idx     <= word_idx + WIDX_ONE;
            end else begin
              asm_q[byte_idx] <= i_rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_du_loader.sv
// Self-checking bench for du_loader: directed frames from the requirement list
// plus random frames scored against a byte-level frame model.
module tb_du_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        o_rd, o_wr, o_tx_start, o_imem_we, o_done, o_error;
  logic [7:0]  o_wdata;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;

  always #5 clk = ~clk;

  du_loader #(.TIMEOUT_TICKS(32'd100)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rx_done(rx_done),
    .i_rx_data(rx_data), .o_rd(o_rd), .o_wr(o_wr), .o_tx_start(o_tx_start),
    .o_wdata(o_wdata), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_done(o_done), .o_error(o_error)
  );

  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [31:0] words[$];
  logic [31:0] mem [0:1023];
  int          nwr = 0, nerr = 0;
  int          total = 0, bad = 0;

  // Rx FIFO model: pop on o_rd at the active edge, present head on the falling edge
  always @(posedge clk) if (o_rd && rxq.size() > 0) rxq.delete(0);

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_imem_we) begin mem[o_imem_addr] = o_imem_wdata; nwr++; end
      if (o_wr) txq.push_back(o_wdata);
      if (o_error) nerr++;
    end
    rx_done = (rxq.size() != 0);
    rx_data = rx_done ? rxq[0] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame model: 16-bit word count, little-endian words, 8-bit sum of data bytes
  task automatic send_frame(input bit corrupt);
    logic [15:0] n;
    logic [7:0]  s;
    n = 16'(words.size());
    s = 8'h00;
    rxq.push_back(n[7:0]);
    rxq.push_back(n[15:8]);
    foreach (words[i])
      for (int b = 0; b < 4; b++) begin
        rxq.push_back(words[i][8*b +: 8]);
        s = s + words[i][8*b +: 8];
      end
    rxq.push_back(corrupt ? s + 8'h01 : s);
  endtask

  task automatic get_tx(input string tag, input logic [7:0] exp, output int waited);
    waited = 0;
    while (txq.size() == 0 && waited < 3000) begin @(negedge clk); waited++; end
    if (txq.size() == 0) chk({tag, "_timeout"}, 32'hDEAD, {24'h0, exp});
    else                 chk(tag, {24'h0, txq.pop_front()}, {24'h0, exp});
  endtask

  task automatic drain_rx();
    int k = 0;
    while (rxq.size() != 0 && k < 5000) begin @(negedge clk); k++; end
    if (rxq.size() != 0) chk("rx_drain", 32'(rxq.size()), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, {23'h0, o_rd, o_wr, o_tx_start, o_imem_we, o_done, o_error,
              o_imem_addr[2:0]}, 32'h0);
    chk({tag, "_wdata"}, {24'h0, o_wdata}, 32'h0);
    chk({tag, "_iaddr"}, {22'h0, o_imem_addr}, 32'h0);
    chk({tag, "_iwdata"}, o_imem_wdata, 32'h0);
  endtask

  initial begin
    int w;
    int n;
    bit corrupt;

    #2 rst_n = 1'b0;
    cyc(2);
    check_quiet("reset");
    rst_n = 1'b1;
    cyc(2);

    // good frame from the requirement example
    words = '{32'h00500093, 32'h1A1A1A1A};
    nwr = 0; start = 1'b1;
    send_frame(1'b0);
    get_tx("ack_basic", 8'h05, w);
    cyc(2);
    chk("done_basic", {31'h0, o_done}, 32'd1);
    chk("mem0_basic", mem[0], 32'h00500093);
    chk("mem1_basic", mem[1], 32'h1A1A1A1A);
    chk("nwr_basic", 32'(nwr), 32'd2);
    start = 1'b0;
    cyc(2);
    chk("done_clear", {31'h0, o_done}, 32'd0);

    // bad checksum, then retransmission within the same session
    nwr = 0; nerr = 0; mem[0] = 32'hDEADBEEF; mem[1] = 32'hDEADBEEF;
    start = 1'b1;
    send_frame(1'b1);
    get_tx("nak_cksum", 8'h15, w);
    cyc(2);
    chk("err_cksum", 32'(nerr), 32'd1);
    chk("nwr_cksum", 32'(nwr), 32'd2);
    chk("mem1_cksum", mem[1], 32'h1A1A1A1A);
    chk("done_cksum", {31'h0, o_done}, 32'd0);
    send_frame(1'b0);
    get_tx("ack_resend", 8'h05, w);
    cyc(2);
    chk("done_resend", {31'h0, o_done}, 32'd1);
    chk("err_resend", 32'(nerr), 32'd1);
    start = 1'b0;
    cyc(2);

    // illegal lengths: zero and 2**NB_IMEM_ADDR+1
    nwr = 0; start = 1'b1;
    rxq.push_back(8'h00); rxq.push_back(8'h00);
    get_tx("nak_len0", 8'h15, w);
    rxq.push_back(8'h01); rxq.push_back(8'h04);
    get_tx("nak_lenmax", 8'h15, w);
    cyc(4);
    chk("nwr_badlen", 32'(nwr), 32'd0);
    start = 1'b0;
    cyc(2);

    // inter-byte timeout after two data bytes of a one-word frame
    nwr = 0; start = 1'b1;
    rxq.push_back(8'h01); rxq.push_back(8'h00);
    rxq.push_back(8'hAA); rxq.push_back(8'hBB);
    drain_rx();
    get_tx("nak_timeout", 8'h15, w);
    chk("timeout_lat", {31'h0, (w >= 98 && w <= 106)}, 32'd1);
    chk("nwr_timeout", 32'(nwr), 32'd0);
    start = 1'b0;
    cyc(2);

    // random frames, good and corrupt; words land in IMEM either way
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 8);
      corrupt = 1'($urandom_range(0, 1));
      words.delete();
      for (int i = 0; i < n; i++) begin
        words.push_back($urandom);
        mem[i] = 32'hDEADBEEF;
      end
      nwr = 0; start = 1'b1;
      send_frame(corrupt);
      get_tx($sformatf("rnd%0d_resp", t), corrupt ? 8'h15 : 8'h05, w);
      cyc(2);
      chk($sformatf("rnd%0d_nwr", t), 32'(nwr), 32'(n));
      for (int i = 0; i < n; i++) chk($sformatf("rnd%0d_mem%0d", t, i), mem[i], words[i]);
      chk($sformatf("rnd%0d_done", t), {31'h0, o_done}, {31'h0, !corrupt});
      start = 1'b0;
      cyc(2);
    end

    // start dropped mid-word: one word written, no reply, FSM idle
    nwr = 0; txq.delete(); start = 1'b1;
    rxq.push_back(8'h02); rxq.push_back(8'h00);
    rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33);
    rxq.push_back(8'h44); rxq.push_back(8'h55);
    drain_rx();
    cyc(2);
    chk("abort_nwr1", 32'(nwr), 32'd1);
    chk("abort_mem0", mem[0], 32'h44332211);
    start = 1'b0;
    cyc(1);
    rxq.push_back(8'h66);
    cyc(2);
    chk("abort_rd", {31'h0, o_rd}, 32'd0);
    cyc(20);
    chk("abort_tx", 32'(txq.size()), 32'd0);
    chk("abort_nwr", 32'(nwr), 32'd1);
    rxq.delete();
    cyc(2);

    // reset asserted in the middle of DATA
    start = 1'b1;
    rxq.push_back(8'h02); rxq.push_back(8'h00);
    rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h03);
    drain_rx();
    cyc(1);
    #2 rst_n = 1'b0;
    #1 check_quiet("rst_mid");
    rxq.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    chk("rst_no_tx", 32'(txq.size()), 32'd0);
    start = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/du_loader.md
DU_LOADER -- requirements
Module: du_loader

Interface
REQ-001 SHALL have parameter NB_INSTRUCTION, default 32, IMEM word width.
REQ-002 SHALL have parameter NB_UART_DATA, default 8, UART byte width.
REQ-003 SHALL have parameter NB_IMEM_ADDR, default 10, IMEM word-address width.
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 32'd99_999_999, inter-byte timeout in clk cycles.
REQ-005 SHALL have port clk  in  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_start  in  1  load enable level from debug master; loader active while high.
REQ-008 SHALL have port i_rx_done  in  1  UART Rx FIFO not empty; i_rx_data valid.
REQ-009 SHALL have port i_rx_data  in  NB_UART_DATA  Rx FIFO head byte.
REQ-010 SHALL have port o_rd  out  1  Rx FIFO pop, combinational.
REQ-011 SHALL have port o_wr  out  1  Tx FIFO write strobe.
REQ-012 SHALL have port o_tx_start  out  1  Tx start, asserted with o_wr.
REQ-013 SHALL have port o_wdata  out  NB_UART_DATA  Tx byte.
REQ-014 SHALL have port o_imem_we  out  1  IMEM write enable.
REQ-015 SHALL have port o_imem_addr  out  NB_IMEM_ADDR  IMEM word address.
REQ-016 SHALL have port o_imem_wdata  out  NB_INSTRUCTION  IMEM write word.
REQ-017 SHALL have port o_done  out  1  level; load accepted; held until i_start low.
REQ-018 SHALL have port o_error  out  1  one-cycle pulse per rejected frame.

Function
REQ-019 Frame format SHALL be: LEN_LO, LEN_HI (16-bit word count N), 4N data bytes (little-endian per word), 1 checksum byte = 8-bit sum mod 256 of data bytes only.
REQ-020 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHECK, RESP, DONE.
REQ-021 IDLE -> LEN_LO when i_start=1; all other states -> IDLE next cycle when i_start=0, with no further IMEM write and no Tx strobe.
REQ-022 In LEN_LO/LEN_HI/DATA/CHECK, o_rd SHALL equal i_rx_done in the same cycle; byte consumed on that edge; o_rd=0 in all other states.
REQ-023 LEN_HI byte consumed: N=0 or N>2**NB_IMEM_ADDR -> RESP with NAK; else -> DATA with word index and byte index cleared.
REQ-024 On 4th byte of a word, o_imem_we SHALL pulse high for exactly one cycle on the next cycle, o_imem_addr=word index, o_imem_wdata={b3,b2,b1,b0}; word index then increments.
REQ-025 Last data byte of word N-1 -> CHECK; checksum byte equal to running sum -> RESP with ACK, else RESP with NAK.
REQ-026 RESP SHALL last one cycle: o_wr=o_tx_start=1, o_wdata=8'h05 (ACK) or 8'h15 (NAK); ACK -> DONE; NAK -> LEN_LO with o_error pulsed same cycle, sum/indices cleared.
REQ-027 Inter-byte counter SHALL clear on every consumed byte and on entry to LEN_LO; reaching TIMEOUT_TICKS in LEN_HI/DATA/CHECK -> RESP with NAK; no timeout in LEN_LO.
REQ-028 DONE: o_done=1, no reads; i_start low -> IDLE, o_done=0 next cycle.
REQ-029 Words already written by a rejected frame SHALL remain in IMEM; retransmission overwrites from address 0.
REQ-030 Checksum and indices SHALL wrap modulo their widths; word index width NB_IMEM_ADDR+1.

Reset
REQ-031 i_rst_n low SHALL asynchronously force IDLE, all counters/sum/assembly registers 0, all outputs 0 (o_rd combinationally 0 in IDLE).
REQ-032 Reset mid-frame SHALL abandon the frame with no ACK/NAK.

Structure
REQ-033 ACK/NAK codes and state encodings SHALL live in a shared debug-unit package also used by du_master.
REQ-034 Implementation SHALL be single-module FSMD; no sub-module.

Verification
REQ-035 N=2, bytes 93 00 50 00 1A 1A 1A 1A, checksum 4B -> writes addr0=32'h00500093, addr1=32'h1A1A1A1A, Tx 05, o_done=1.
REQ-036 Same frame, checksum 4C -> both words written, Tx 15, o_error pulse, back to LEN_LO; resend with 4B -> Tx 05, o_done.
REQ-037 LEN bytes 00 00 -> Tx 15, no IMEM write; LEN=2**NB_IMEM_ADDR+1 -> Tx 15.
REQ-038 N=1, 2 data bytes then silence TIMEOUT_TICKS (bench overrides to 100) -> Tx 15, no IMEM write.
REQ-039 i_start dropped after 5 data bytes of N=2 -> IDLE next cycle, exactly one IMEM write, no Tx; i_rst_n pulsed mid-DATA -> all outputs 0 immediately.
